uart_sid_cmd: RTL and testbench

- Command parser and sequencer between the UART receiver byte stream and the SID register write port.
- Consumes 8-bit AXI4-Stream bytes and assembles 4-byte write frames: SYNC, ADDR, DATA, CSUM.
- Validates each frame, then issues one ready/valid register write per good frame.
- Monitors receiver frame/overrun pulses, enforces an inter-byte timeout and exposes command/error counters.

---
 rtl/uart_sid_cmd.sv | 94 +++++++++
 tb/tb_uart_sid_cmd.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_sid_cmd.sv
// uart_sid_cmd: parses SYNC/ADDR/DATA/CSUM byte frames from the UART receiver into SID register writes,
// with inter-byte timeout, receiver error handling and command/error counters.
module uart_sid_cmd #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter logic [4:0] MAX_ADDR       = 5'h1C,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        rx_frame_error,
    input  logic        rx_overrun_error,
    output logic [4:0]  reg_addr,
    output logic [7:0]  reg_data,
    output logic        reg_wr_valid,
    input  logic        reg_wr_ready,
    output logic        busy,
    output logic [15:0] cmd_count,
    output logic [7:0]  err_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, WRITE} state_t;
    state_t state, state_n;
    logic [7:0] addr_tmp, data_tmp, sum;
    logic [TW-1:0] tmo;
    logic acc, rx_err, frame, load, wr_load, done, err_ev, expired;
    assign s_axis_tready = state != WRITE;
    assign busy = state != IDLE;
    assign acc = s_axis_tvalid & s_axis_tready;
    assign rx_err = rx_frame_error | rx_overrun_error;
    assign frame = state inside {ADDR, DATA, CSUM};
    assign sum = addr_tmp + data_tmp;
    assign expired = ~acc & (tmo == '0);
    always_comb begin
        state_n = state;
        load    = 1'b0;
        wr_load = 1'b0;
        done    = 1'b0;
        err_ev  = rx_err;
        case (state)
            IDLE: if (acc && !rx_err && s_axis_tdata == SYNC_BYTE) begin
                state_n = ADDR;
                load    = 1'b1;
            end
            ADDR, DATA: if (rx_err) state_n = IDLE;
                else if (acc) begin
                    state_n = state == DATA ? CSUM : s_axis_tdata == SYNC_BYTE ? ADDR : DATA;
                    load    = 1'b1;
                end else if (expired) begin
                    state_n = IDLE;
                    err_ev  = 1'b1;
                end
            CSUM: if (rx_err) state_n = IDLE;
                else if (acc) begin
                    wr_load = s_axis_tdata == sum && addr_tmp <= {3'b000, MAX_ADDR};
                    state_n = wr_load ? WRITE : IDLE;
                    err_ev  = !wr_load;
                end else if (expired) begin
                    state_n = IDLE;
                    err_ev  = 1'b1;
                end
            WRITE: if (reg_wr_ready) begin
                state_n = IDLE;
                done    = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tmo          <= '0;
            addr_tmp     <= '0;
            data_tmp     <= '0;
            reg_addr     <= '0;
            reg_data     <= '0;
            reg_wr_valid <= 1'b0;
            cmd_count    <= '0;
            err_count    <= '0;
        end else begin
            state        <= state_n;
            tmo          <= load ? TW'(TIMEOUT_CYCLES - 1) : (frame && tmo != '0) ? tmo - 1'b1 : tmo;
            addr_tmp     <= (state == ADDR && acc) ? s_axis_tdata : addr_tmp;
            data_tmp     <= (state == DATA && acc) ? s_axis_tdata : data_tmp;
            reg_addr     <= wr_load ? addr_tmp[4:0] : reg_addr;
            reg_data     <= wr_load ? data_tmp : reg_data;
            reg_wr_valid <= state_n == WRITE;
            cmd_count    <= done ? cmd_count + 16'd1 : cmd_count;
            err_count    <= (err_ev && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
        end
    end
endmodule

// File: tb/tb_uart_sid_cmd.sv
// tb_uart_sid_cmd: directed plus randomized frames checked against a byte-level frame model with a write scoreboard.
module tb_uart_sid_cmd;
    localparam int T = 16;
    logic        clk = 0, rst = 1;
    logic [7:0]  s_axis_tdata = 0;
    logic        s_axis_tvalid = 0, s_axis_tready;
    logic        rx_frame_error = 0, rx_overrun_error = 0;
    logic [4:0]  reg_addr;
    logic [7:0]  reg_data;
    logic        reg_wr_valid, reg_wr_ready = 1, busy;
    logic [15:0] cmd_count;
    logic [7:0]  err_count;
    uart_sid_cmd #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .rx_frame_error(rx_frame_error), .rx_overrun_error(rx_overrun_error),
        .reg_addr(reg_addr), .reg_data(reg_data), .reg_wr_valid(reg_wr_valid), .reg_wr_ready(reg_wr_ready),
        .busy(busy), .cmd_count(cmd_count), .err_count(err_count)
    );
    always #5 clk = ~clk;
    int checks = 0, errors = 0;
    int cyc = 0, last = 0, phase = 0;
    int m_addr, m_data, m_err = 0;
    logic [15:0] m_cmd = 0;
    logic [12:0] exp_q[$];
    bit rnd_rdy = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    // Frame model: phase counts bytes collected since SYNC (0 = waiting for SYNC)
    function automatic void err_inc();
        if (m_err < 255) m_err++;
    endfunction
    function automatic void expire(input int e);
        if (phase != 0 && e > last + T) begin
            err_inc();
            phase = 0;
        end
    endfunction
    function automatic void model_byte(input int b, input int e);
        expire(e);
        last = e;
        case (phase)
            0: if (b == 8'hA5) phase = 1;
            1: if (b != 8'hA5) begin m_addr = b; phase = 2; end
            2: begin m_data = b; phase = 3; end
            default: begin
                if (b == (m_addr + m_data) % 256 && m_addr <= 28) begin
                    exp_q.push_back({m_addr[4:0], m_data[7:0]});
                    m_cmd++;
                end else err_inc();
                phase = 0;
            end
        endcase
    endfunction
    function automatic void model_err(input int e);
        expire(e);
        err_inc();
        phase = 0;
    endfunction
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        if (rnd_rdy) reg_wr_ready = 1'($urandom_range(0, 1));
    endtask
    task automatic send(input logic [7:0] b, input bit with_err = 0);
        int n = 0;
        s_axis_tdata = b;
        s_axis_tvalid = 1;
        while (!s_axis_tready && n < 200) begin step(); n++; end
        if (n >= 200) chk("tready_wait", 0, 1);
        rx_frame_error = with_err;
        step();
        s_axis_tvalid = 0;
        rx_frame_error = 0;
        if (with_err) model_err(cyc); else model_byte(b, cyc);
    endtask
    task automatic pulse(input bit overrun);
        if (overrun) rx_overrun_error = 1; else rx_frame_error = 1;
        step();
        rx_overrun_error = 0;
        rx_frame_error = 0;
        model_err(cyc);
    endtask
    task automatic frame4(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5); send(a); send(d); send(c);
    endtask
    task automatic check_counts(input string tag);
        int n = 0;
        step(); step();
        while ((exp_q.size() != 0 || reg_wr_valid) && n < 100) begin step(); n++; end
        expire(cyc + 1);
        chk({tag, "_queue"}, exp_q.size(), 0);
        chk({tag, "_err"}, err_count, m_err);
        chk({tag, "_cmd"}, cmd_count, m_cmd);
        chk({tag, "_busy"}, busy, phase != 0);
    endtask
    task automatic check_reset(input string tag);
        chk({tag, "_tready"}, s_axis_tready, 1);
        chk({tag, "_valid"}, reg_wr_valid, 0);
        chk({tag, "_addr"}, reg_addr, 0);
        chk({tag, "_data"}, reg_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cmd"}, cmd_count, 0);
        chk({tag, "_errc"}, err_count, 0);
    endtask
    always @(negedge clk) begin
        if (!rst && reg_wr_valid) begin
            if (exp_q.size() == 0) chk("unexpected_write", {reg_addr, reg_data}, 0);
            else begin
                chk("wr_addr", reg_addr, exp_q[0][12:8]);
                chk("wr_data", reg_data, exp_q[0][7:0]);
                chk("wr_tready_low", s_axis_tready, 0);
                if (reg_wr_ready) void'(exp_q.pop_front());
            end
        end
    end
    initial begin
        step(); step();
        check_reset("reset");
        rst = 0;
        step();
        frame4(8'h04, 8'h3C, 8'h40);
        chk("valid_after_csum", reg_wr_valid, 1);
        check_counts("basic");
        reg_wr_ready = 0;
        frame4(8'h18, 8'h0F, 8'h27);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", reg_wr_valid, 1);
            step();
        end
        reg_wr_ready = 1;
        check_counts("stall");
        frame4(8'h04, 8'h3C, 8'h41);
        check_counts("bad_csum");
        frame4(8'h1D, 8'h00, 8'h1D);
        check_counts("bad_addr");
        send(8'hA5);
        frame4(8'h02, 8'hFF, 8'h01);
        send(8'h55); send(8'h00);
        check_counts("resync");
        send(8'hA5); send(8'h07);
        for (int i = 0; i < 16; i++) step();
        send(8'h30); send(8'h37);
        check_counts("timeout");
        send(8'hA5); send(8'h03);
        for (int i = 0; i < 15; i++) step();
        send(8'h04); send(8'h07);
        check_counts("timeout_edge");
        send(8'hA5); send(8'h01);
        pulse(0);
        check_counts("abort_data");
        reg_wr_ready = 0;
        frame4(8'h01, 8'h02, 8'h03);
        pulse(1);
        reg_wr_ready = 1;
        check_counts("err_in_write");
        send(8'hA5); send(8'h05, 1); send(8'h06); send(8'h0B);
        check_counts("byte_with_err");
        rnd_rdy = 1;
        for (int f = 0; f < 120; f++) begin
            logic [7:0] a, d, c;
            a = 8'($urandom_range(0, 31));
            d = 8'($urandom);
            c = ($urandom_range(0, 9) == 0) ? 8'($urandom) : a + d;
            for (int k = 0; k < 4; k++) begin
                int g;
                logic [7:0] b;
                g = ($urandom_range(0, 19) == 0) ? 17 : $urandom_range(0, 2);
                for (int i = 0; i < g; i++) step();
                if ($urandom_range(0, 29) == 0) pulse(1'($urandom_range(0, 1)));
                b = k == 0 ? 8'hA5 : k == 1 ? a : k == 2 ? d : c;
                send(b, $urandom_range(0, 39) == 0);
            end
        end
        rnd_rdy = 0;
        reg_wr_ready = 1;
        check_counts("random");
        for (int i = 0; i < 300; i++) pulse(1'(i % 2));
        check_counts("saturate");
        chk("err_sat", err_count, 8'hFF);
        send(8'hA5); send(8'h01);
        rst = 1;
        step();
        exp_q.delete();
        phase = 0; m_err = 0; m_cmd = 0;
        check_reset("midreset");
        rst = 0;
        frame4(8'h1C, 8'h80, 8'h9C);
        check_counts("post_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
